// File: rtl/decode_pkg.sv
// decode_pkg: shared definitions for the decode stage.
//   - opcode constants (OPC_LD, OPC_LDI, OPC_BR)
//   - field-extract helpers for the {opcode, src1, src2, dest} instruction
//     layout, parametrised on the register-address and opcode widths
//   - idex_ctl_t: control half of the ID/EX boundary (valid + branch pulse)
package decode_pkg;

  localparam int INST_MAX_W  = 64;
  localparam int FIELD_MAX_W = 16;

  localparam logic [3:0] OPC_LD  = 4'hD;
  localparam logic [3:0] OPC_LDI = 4'hE;
  localparam logic [3:0] OPC_BR  = 4'hF;

  typedef struct packed {
    logic valid;
    logic branch;
  } idex_ctl_t;

  function automatic logic [FIELD_MAX_W-1:0] field_at(
    input logic [INST_MAX_W-1:0] inst,
    input int                    lsb,
    input int                    w
  );
    logic [INST_MAX_W-1:0] mask;
    mask = (INST_MAX_W'(1) << w) - INST_MAX_W'(1);
    return FIELD_MAX_W'((inst >> lsb) & mask);
  endfunction

  function automatic logic [FIELD_MAX_W-1:0] get_opcode(
    input logic [INST_MAX_W-1:0] inst, input int reg_aw, input int opc_w);
    return field_at(inst, 3 * reg_aw, opc_w);
  endfunction

  function automatic logic [FIELD_MAX_W-1:0] get_src1(
    input logic [INST_MAX_W-1:0] inst, input int reg_aw);
    return field_at(inst, 2 * reg_aw, reg_aw);
  endfunction

  function automatic logic [FIELD_MAX_W-1:0] get_src2(
    input logic [INST_MAX_W-1:0] inst, input int reg_aw);
    return field_at(inst, reg_aw, reg_aw);
  endfunction

  function automatic logic [FIELD_MAX_W-1:0] get_dest(
    input logic [INST_MAX_W-1:0] inst, input int reg_aw);
    return field_at(inst, 0, reg_aw);
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: 2**AW x DATA_W register file, two asynchronous read ports,
// one synchronous write port.
//   clk, rst_n            clock, asynchronous active-low reset (clears all)
//   rd_addr1/rd_data1     read port 1
//   rd_addr2/rd_data2     read port 2
//   wr_en/wr_addr/wr_data write port, lands at the clock edge
// Register 0 always reads zero and ignores writes. A read of the address
// being written in the same cycle returns the write data (bypass).
module regfile_2r1w #(
  parameter int DATA_W = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     rd_addr1,
  output logic [DATA_W-1:0] rd_data1,
  input  logic [AW-1:0]     rd_addr2,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] regs [2**AW];

  logic wr_live;
  assign wr_live = wr_en && (wr_addr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**AW; i++) regs[i] <= '0;
    end else if (wr_live) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_data1 = (rd_addr1 == '0)                 ? '0      :
                    (wr_live && wr_addr == rd_addr1) ? wr_data :
                                                       regs[rd_addr1];
  assign rd_data2 = (rd_addr2 == '0)                 ? '0      :
                    (wr_live && wr_addr == rd_addr2) ? wr_data :
                                                       regs[rd_addr2];

endmodule

// File: rtl/decode_stage_p.sv
// decode_stage_p: decode stage between fetch and execute.
//   clk, reset                    clock, asynchronous active-low reset
//   i_inst_valid, i_inst, i_pc    instruction from fetch {opcode,src1,src2,dest}
//   i_hold                        execute cannot accept; ID/EX frozen
//   i_flush                       squash ID/EX and any pending branch kill
//   i_wb_en/i_wb_addr/i_wb_data   write-back port into the register file
//   o_stall                       combinational; fetch re-presents next cycle
//   o_valid, o_opcode, o_src1, o_src2, o_dest, o_data1, o_data2, o_pc
//                                 registered ID/EX contents
//   o_branch, o_branch_target     branch in ID/EX and its target
module decode_stage_p
  import decode_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int OPC_W  = 4,
  parameter int PC_W   = 12,
  parameter int INST_W = OPC_W + 3 * REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_inst_valid,
  input  logic [INST_W-1:0] i_inst,
  input  logic [PC_W-1:0]   i_pc,
  input  logic              i_hold,
  input  logic              i_flush,
  input  logic              i_wb_en,
  input  logic [REG_AW-1:0] i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  output logic              o_stall,
  output logic              o_valid,
  output logic [OPC_W-1:0]  o_opcode,
  output logic [REG_AW-1:0] o_src1,
  output logic [REG_AW-1:0] o_src2,
  output logic [REG_AW-1:0] o_dest,
  output logic [DATA_W-1:0] o_data1,
  output logic [DATA_W-1:0] o_data2,
  output logic [PC_W-1:0]   o_pc,
  output logic              o_branch,
  output logic [PC_W-1:0]   o_branch_target
);

  if (INST_W != OPC_W + 3 * REG_AW) begin : g_inst_w_illegal
    $error("decode_stage_p: INST_W must equal OPC_W + 3*REG_AW");
  end

  localparam logic [OPC_W-1:0] OP_LD  = OPC_W'(OPC_LD);
  localparam logic [OPC_W-1:0] OP_LDI = OPC_W'(OPC_LDI);
  localparam logic [OPC_W-1:0] OP_BR  = OPC_W'(OPC_BR);

  // ---- stage p0: field split, register read, immediate and target ----
  logic [INST_MAX_W-1:0]    inst_x_p0;
  logic [OPC_W-1:0]         opc_p0;
  logic [REG_AW-1:0]        src1_p0, src2_p0, dest_p0;
  logic [DATA_W-1:0]        rd1_p0, rd2_p0, data2_p0;
  logic signed [PC_W-1:0]   off_p0;
  logic [PC_W-1:0]          tgt_p0;
  logic                     is_br_p0;

  assign inst_x_p0 = INST_MAX_W'(i_inst);
  assign opc_p0    = OPC_W'(get_opcode(inst_x_p0, REG_AW, OPC_W));
  assign src1_p0   = REG_AW'(get_src1(inst_x_p0, REG_AW));
  assign src2_p0   = REG_AW'(get_src2(inst_x_p0, REG_AW));
  assign dest_p0   = REG_AW'(get_dest(inst_x_p0, REG_AW));

  regfile_2r1w #(
    .DATA_W (DATA_W),
    .AW     (REG_AW)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (reset),
    .rd_addr1 (src1_p0),
    .rd_data1 (rd1_p0),
    .rd_addr2 (src2_p0),
    .rd_data2 (rd2_p0),
    .wr_en    (i_wb_en),
    .wr_addr  (i_wb_addr),
    .wr_data  (i_wb_data)
  );

  // LDI carries its immediate in the src2/dest fields instead of a register
  assign data2_p0 = (opc_p0 == OP_LDI) ? DATA_W'({src2_p0, dest_p0}) : rd2_p0;

  assign off_p0   = PC_W'($signed(dest_p0));
  assign tgt_p0   = i_pc + $unsigned(off_p0);
  assign is_br_p0 = (opc_p0 == OP_BR);

  // ---- stage p1: ID/EX register ----
  idex_ctl_t          ctl_p1;
  logic               kill_p1;
  logic [OPC_W-1:0]   opc_p1;
  logic [REG_AW-1:0]  src1_p1, src2_p1, dest_p1;
  logic [DATA_W-1:0]  data1_p1, data2_p1;
  logic [PC_W-1:0]    pc_p1, tgt_p1;

  logic hazard, accept_vld, wb_hit1, wb_hit2;

  // Load result is not available until after execute, so a dependent
  // instruction right behind a load must wait one cycle.
  assign hazard = ctl_p1.valid && (opc_p1 == OP_LD) && (dest_p1 != '0) &&
                  ((dest_p1 == src1_p0) || (dest_p1 == src2_p0)) &&
                  i_inst_valid;

  // Gated by reset so the stall is low while reset is asserted.
  assign o_stall    = reset && (i_hold || hazard);
  assign accept_vld = i_inst_valid && !kill_p1;

  // Held operands track write-back so they never go stale; an LDI operand2
  // is an immediate and is left alone.
  assign wb_hit1 = i_wb_en && (i_wb_addr != '0) && (i_wb_addr == src1_p1);
  assign wb_hit2 = i_wb_en && (i_wb_addr != '0) && (i_wb_addr == src2_p1) &&
                   (opc_p1 != OP_LDI);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctl_p1   <= '0;
      kill_p1  <= 1'b0;
      opc_p1   <= '0;
      src1_p1  <= '0;
      src2_p1  <= '0;
      dest_p1  <= '0;
      data1_p1 <= '0;
      data2_p1 <= '0;
      pc_p1    <= '0;
      tgt_p1   <= '0;
    end else if (i_flush) begin
      ctl_p1  <= '0;
      kill_p1 <= 1'b0;
    end else if (i_hold) begin
      if (wb_hit1) data1_p1 <= i_wb_data;
      if (wb_hit2) data2_p1 <= i_wb_data;
    end else if (hazard) begin
      ctl_p1 <= '0;
    end else begin
      ctl_p1.valid  <= accept_vld;
      ctl_p1.branch <= accept_vld && is_br_p0;
      // The kill is consumed by the next real instruction; fetch bubbles
      // leave it pending.
      if (i_inst_valid) kill_p1 <= accept_vld && is_br_p0;
      opc_p1   <= opc_p0;
      src1_p1  <= src1_p0;
      src2_p1  <= src2_p0;
      dest_p1  <= dest_p0;
      data1_p1 <= rd1_p0;
      data2_p1 <= data2_p0;
      pc_p1    <= i_pc;
      tgt_p1   <= tgt_p0;
    end
  end

  assign o_valid         = ctl_p1.valid;
  assign o_branch        = ctl_p1.branch;
  assign o_opcode        = opc_p1;
  assign o_src1          = src1_p1;
  assign o_src2          = src2_p1;
  assign o_dest          = dest_p1;
  assign o_data1         = data1_p1;
  assign o_data2         = data2_p1;
  assign o_pc            = pc_p1;
  assign o_branch_target = tgt_p1;

endmodule

// File: tb/tb_decode_stage_p.sv
module tb_decode_stage_p;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_inst_valid;
  logic [15:0] i_inst;
  logic [11:0] i_pc;
  logic        i_hold, i_flush, i_wb_en;
  logic [3:0]  i_wb_addr;
  logic [15:0] i_wb_data;
  logic        o_stall, o_valid, o_branch;
  logic [3:0]  o_opcode, o_src1, o_src2, o_dest;
  logic [15:0] o_data1, o_data2;
  logic [11:0] o_pc, o_branch_target;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_stage_p dut (
    .clk             (clk),
    .reset           (reset),
    .i_inst_valid    (i_inst_valid),
    .i_inst          (i_inst),
    .i_pc            (i_pc),
    .i_hold          (i_hold),
    .i_flush         (i_flush),
    .i_wb_en         (i_wb_en),
    .i_wb_addr       (i_wb_addr),
    .i_wb_data       (i_wb_data),
    .o_stall         (o_stall),
    .o_valid         (o_valid),
    .o_opcode        (o_opcode),
    .o_src1          (o_src1),
    .o_src2          (o_src2),
    .o_dest          (o_dest),
    .o_data1         (o_data1),
    .o_data2         (o_data2),
    .o_pc            (o_pc),
    .o_branch        (o_branch),
    .o_branch_target (o_branch_target)
  );

  typedef struct {
    logic        iv;
    logic [15:0] inst;
    logic [11:0] pc;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        e_stall;
    logic        e_valid;
    logic        e_branch;
    logic        chk_f;
    logic [15:0] e_d1;
    logic [15:0] e_d2;
    logic [11:0] e_pc;
    logic [11:0] e_tgt;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(
    input logic iv, input logic [15:0] inst, input logic [11:0] pc,
    input logic wb_en, input logic [3:0] wb_addr, input logic [15:0] wb_data,
    input logic e_stall, input logic e_valid, input logic e_branch,
    input logic chk_f, input logic [15:0] e_d1, input logic [15:0] e_d2,
    input logic [11:0] e_pc, input logic [11:0] e_tgt);
    vec_t v;
    v.iv = iv; v.inst = inst; v.pc = pc;
    v.wb_en = wb_en; v.wb_addr = wb_addr; v.wb_data = wb_data;
    v.e_stall = e_stall; v.e_valid = e_valid; v.e_branch = e_branch;
    v.chk_f = chk_f; v.e_d1 = e_d1; v.e_d2 = e_d2; v.e_pc = e_pc; v.e_tgt = e_tgt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [15:0] inst, input logic [11:0] pc,
                       input logic hold, input logic flush, input logic wb_en,
                       input logic [3:0] wa, input logic [15:0] wd);
    i_inst_valid = iv; i_inst = inst; i_pc = pc;
    i_hold = hold; i_flush = flush;
    i_wb_en = wb_en; i_wb_addr = wa; i_wb_data = wd;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"},  {31'd0, o_stall},  32'd0);
    chk({tag, "_valid"},  {31'd0, o_valid},  32'd0);
    chk({tag, "_branch"}, {31'd0, o_branch}, 32'd0);
    chk({tag, "_fields"}, {16'd0, o_opcode, o_src1, o_src2, o_dest}, 32'd0);
    chk({tag, "_data1"},  {16'd0, o_data1},  32'd0);
    chk({tag, "_data2"},  {16'd0, o_data2},  32'd0);
    chk({tag, "_pc"},     {20'd0, o_pc},     32'd0);
    chk({tag, "_tgt"},    {20'd0, o_branch_target}, 32'd0);
  endtask

  initial begin
    //                iv inst     pc      wb a  data     st v  br f  d1       d2       pc      tgt
    vecs[0]  = mk(1, 16'h1300, 12'h010, 1, 3, 16'h1234, 0, 1, 0, 1, 16'h1234, 16'h0000, 12'h010, 12'h010);
    vecs[1]  = mk(1, 16'h1000, 12'h011, 1, 0, 16'hFFFF, 0, 1, 0, 1, 16'h0000, 16'h0000, 12'h011, 12'h011);
    vecs[2]  = mk(1, 16'h2030, 12'h012, 0, 0, 16'h0000, 0, 1, 0, 1, 16'h0000, 16'h1234, 12'h012, 12'h012);
    vecs[3]  = mk(1, 16'hE0AB, 12'h013, 0, 0, 16'h0000, 0, 1, 0, 1, 16'h0000, 16'h00AB, 12'h013, 12'h00E);
    vecs[4]  = mk(1, 16'hD035, 12'h014, 0, 0, 16'h0000, 0, 1, 0, 1, 16'h0000, 16'h1234, 12'h014, 12'h019);
    vecs[5]  = mk(1, 16'h1520, 12'h015, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 16'h0000, 12'h000, 12'h000);
    vecs[6]  = mk(1, 16'h1520, 12'h015, 1, 5, 16'h0BEE, 0, 1, 0, 1, 16'h0BEE, 16'h0000, 12'h015, 12'h015);
    vecs[7]  = mk(1, 16'hF00E, 12'h005, 0, 0, 16'h0000, 0, 1, 1, 1, 16'h0000, 16'h0000, 12'h005, 12'h003);
    vecs[8]  = mk(1, 16'h1300, 12'h006, 0, 0, 16'h0000, 0, 0, 0, 1, 16'h1234, 16'h0000, 12'h006, 12'h006);
    vecs[9]  = mk(1, 16'h1300, 12'h007, 0, 0, 16'h0000, 0, 1, 0, 1, 16'h1234, 16'h0000, 12'h007, 12'h007);
    vecs[10] = mk(1, 16'hD036, 12'h008, 0, 0, 16'h0000, 0, 1, 0, 1, 16'h0000, 16'h1234, 12'h008, 12'h00E);
    vecs[11] = mk(0, 16'h1600, 12'h009, 0, 0, 16'h0000, 0, 0, 0, 1, 16'h0000, 16'h0000, 12'h009, 12'h009);
    vecs[12] = mk(1, 16'hD037, 12'h00A, 0, 0, 16'h0000, 0, 1, 0, 1, 16'h0000, 16'h1234, 12'h00A, 12'h011);
    vecs[13] = mk(1, 16'h2070, 12'h00B, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 16'h0000, 12'h000, 12'h000);
    vecs[14] = mk(1, 16'h2070, 12'h00B, 0, 0, 16'h0000, 0, 1, 0, 1, 16'h0000, 16'h0000, 12'h00B, 12'h00B);

    // Reset with hold asserted: outputs and stall must be 0.
    reset = 1'b0;
    drive(1, 16'h1300, 12'h0FF, 1, 0, 1, 3, 16'hAAAA);
    #2;
    chk_all_zero("rst_init");
    @(negedge clk);
    reset = 1'b1;

    // Table-driven single-cycle vectors.
    for (int i = 0; i < 15; i++) begin
      vec_t v;
      v = vecs[i];
      drive(v.iv, v.inst, v.pc, 0, 0, v.wb_en, v.wb_addr, v.wb_data);
      #1;
      chk($sformatf("v%0d_stall", i), {31'd0, o_stall}, {31'd0, v.e_stall});
      tick();
      chk($sformatf("v%0d_valid", i),  {31'd0, o_valid},  {31'd0, v.e_valid});
      chk($sformatf("v%0d_branch", i), {31'd0, o_branch}, {31'd0, v.e_branch});
      if (v.chk_f) begin
        chk($sformatf("v%0d_fields", i), {16'd0, o_opcode, o_src1, o_src2, o_dest},
            {16'd0, v.inst});
        chk($sformatf("v%0d_data1", i), {16'd0, o_data1}, {16'd0, v.e_d1});
        chk($sformatf("v%0d_data2", i), {16'd0, o_data2}, {16'd0, v.e_d2});
        chk($sformatf("v%0d_pc", i),    {20'd0, o_pc},    {20'd0, v.e_pc});
        chk($sformatf("v%0d_tgt", i),   {20'd0, o_branch_target}, {20'd0, v.e_tgt});
      end
    end

    // Hold for three cycles while write-back updates the held operands.
    drive(1, 16'h1340, 12'h020, 0, 0, 0, 0, 16'h0000);
    tick();
    chk("h0_data1", {16'd0, o_data1}, 32'h1234);
    chk("h0_data2", {16'd0, o_data2}, 32'h0000);
    drive(1, 16'h2100, 12'h021, 1, 0, 1, 4, 16'h0042);
    #1;
    chk("h1_stall", {31'd0, o_stall}, 32'd1);
    tick();
    chk("h1_data2", {16'd0, o_data2}, 32'h0042);
    chk("h1_fields", {16'd0, o_opcode, o_src1, o_src2, o_dest}, 32'h1340);
    chk("h1_pc", {20'd0, o_pc}, 32'h020);
    drive(1, 16'h2100, 12'h021, 1, 0, 1, 3, 16'h5555);
    tick();
    chk("h2_data1", {16'd0, o_data1}, 32'h5555);
    chk("h2_data2", {16'd0, o_data2}, 32'h0042);
    drive(1, 16'h2100, 12'h021, 1, 0, 1, 9, 16'h7777);
    tick();
    chk("h3_data", {o_data1, o_data2}, 32'h5555_0042);
    chk("h3_valid", {31'd0, o_valid}, 32'd1);
    chk("h3_pc", {20'd0, o_pc}, 32'h020);
    drive(1, 16'h2100, 12'h021, 1, 1, 0, 0, 16'h0000);
    tick();
    chk("h4_flush_valid", {31'd0, o_valid}, 32'd0);
    drive(1, 16'h1400, 12'h022, 0, 0, 0, 0, 16'h0000);
    tick();
    chk("h5_valid", {31'd0, o_valid}, 32'd1);
    chk("h5_data1", {16'd0, o_data1}, 32'h0042);
    chk("h5_pc", {20'd0, o_pc}, 32'h022);

    // Branch held in ID/EX keeps o_branch high; flush clears it and the kill.
    drive(1, 16'hF00E, 12'h030, 0, 0, 0, 0, 16'h0000);
    tick();
    chk("b0_branch", {31'd0, o_branch}, 32'd1);
    chk("b0_tgt", {20'd0, o_branch_target}, 32'h02E);
    for (int k = 1; k <= 2; k++) begin
      drive(1, 16'h1300, 12'h031, 1, 0, 0, 0, 16'h0000);
      tick();
      chk($sformatf("b%0d_branch_hold", k), {31'd0, o_branch}, 32'd1);
      chk($sformatf("b%0d_tgt_hold", k), {20'd0, o_branch_target}, 32'h02E);
    end
    drive(1, 16'h1300, 12'h031, 0, 1, 0, 0, 16'h0000);
    tick();
    chk("b3_flush", {30'd0, o_valid, o_branch}, 32'd0);
    drive(1, 16'h1300, 12'h031, 0, 0, 0, 0, 16'h0000);
    tick();
    chk("b4_valid_after_flush", {31'd0, o_valid}, 32'd1);
    chk("b4_data1", {16'd0, o_data1}, 32'h5555);

    // Reset asserted mid-stream clears everything at once.
    drive(1, 16'hF00E, 12'h032, 0, 0, 0, 0, 16'h0000);
    tick();
    chk("r0_branch", {31'd0, o_branch}, 32'd1);
    #2;
    reset = 1'b0;
    i_hold = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    @(negedge clk);
    reset = 1'b1;
    drive(1, 16'h1300, 12'h040, 0, 0, 0, 0, 16'h0000);
    tick();
    chk("r1_valid", {31'd0, o_valid}, 32'd1);
    chk("r1_fields", {16'd0, o_opcode, o_src1, o_src2, o_dest}, 32'h1300);
    chk("r1_data1", {16'd0, o_data1}, 32'h0000);
    chk("r1_pc", {20'd0, o_pc}, 32'h040);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
